canon_sequencer: RTL and testbench

//  Parametrised N-voice round ("canon") sequencer. Voices share one external note ROM and one external

---
 rtl/canon_sequencer.sv | 111 +++++++++++
 tb/tb_canon_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canon_sequencer.sv
// N-voice round sequencer: one voice per clk shares the note ROM and divider table,
// emitting a {slot, divider} stream for a downstream time-multiplexed tone generator.
module canon_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int SLOT_W     = 2,
    parameter int IDX_W      = 9,
    parameter int DIV_W      = 12,
    parameter int BEAT_W     = 24,
    parameter int VOICE_LAG  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  restart,
    input  logic [BEAT_W-1:0]     tempo,
    input  logic [NUM_VOICES-1:0] voice_mute,
    input  logic [IDX_W-1:0]      loop_start,
    input  logic [IDX_W-1:0]      loop_end,
    output logic [IDX_W-1:0]      rom_addr,
    input  logic [7:0]            rom_data,
    output logic [5:0]            freq_note,
    input  logic [DIV_W-1:0]      freq_div,
    output logic [SLOT_W-1:0]     out_slot,
    output logic [DIV_W-1:0]      divider_out,
    output logic                  out_valid,
    output logic                  beat,
    output logic                  loop_wrap
);

    localparam int HOLD_MAX = (NUM_VOICES - 1) * VOICE_LAG;
    localparam int HOLD_W   = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);

    logic [SLOT_W-1:0]     slot;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [IDX_W-1:0]      idx     [NUM_VOICES];
    logic [5:0]            elapsed [NUM_VOICES];
    logic [HOLD_W-1:0]     hold    [NUM_VOICES];
    logic [NUM_VOICES-1:0] pending;

    logic              cur_entered;
    logic [BEAT_W-1:0] beat_lim;
    logic              beat_wrap;
    logic [6:0]        dur;
    logic [6:0]        elapsed_inc;
    logic              service;
    logic              do_advance;
    logic              at_end;
    logic [IDX_W-1:0]  next_idx;
    logic              out_silent;

    assign rom_addr  = idx[slot];
    assign freq_note = rom_data[5:0];

    // Tempo is clamped so the beat period never drops below one full slot rotation.
    always_comb begin
        cur_entered = (hold[slot] == '0);
        beat_lim    = (tempo < BEAT_W'(NUM_VOICES - 1)) ? BEAT_W'(NUM_VOICES - 1) : tempo;
        beat_wrap   = play && (beat_cnt >= beat_lim);
        dur         = 7'd1 << {rom_data[7:6], 1'b0};
        elapsed_inc = {1'b0, elapsed[slot]} + 7'd1;
        service     = play && pending[slot];
        do_advance  = service && cur_entered && (elapsed_inc >= dur);
        at_end      = (idx[slot] >= loop_end);
        next_idx    = at_end ? loop_start : idx[slot] + IDX_W'(1);
        out_silent  = voice_mute[slot] || !cur_entered || !play || (rom_data[5:0] == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            slot        <= '0;
            beat_cnt    <= '0;
            pending     <= '0;
            out_slot    <= '0;
            divider_out <= '0;
            out_valid   <= 1'b0;
            beat        <= 1'b0;
            loop_wrap   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                idx[v]     <= loop_start;
                elapsed[v] <= '0;
                hold[v]    <= HOLD_W'(v * VOICE_LAG);
            end
        end else begin
            slot        <= slot + SLOT_W'(1);
            out_slot    <= slot;
            out_valid   <= 1'b1;
            divider_out <= out_silent ? '0 : freq_div;
            beat        <= beat_wrap;
            loop_wrap   <= do_advance && at_end && (slot == '0);
            if (play) begin
                beat_cnt <= beat_wrap ? '0 : beat_cnt + BEAT_W'(1);
            end
            if (service) begin
                pending[slot] <= 1'b0;
                if (!cur_entered) begin
                    hold[slot] <= hold[slot] - HOLD_W'(1);
                end else if (do_advance) begin
                    idx[slot]     <= next_idx;
                    elapsed[slot] <= '0;
                end else begin
                    elapsed[slot] <= elapsed_inc[5:0];
                end
            end
            // A new beat must win over this cycle's clear of the serviced slot.
            if (beat_wrap) begin
                pending <= '1;
            end
        end
    end

endmodule

// File: tb/tb_canon_sequencer.sv
// Self-checking bench for canon_sequencer: directed canon scenarios plus randomized
// play/tempo/mute/loop activity against a rule-level reference model.
module tb_canon_sequencer;

    localparam int N      = 4;
    localparam int SLOT_W = 2;
    localparam int IDX_W  = 9;
    localparam int DIV_W  = 12;
    localparam int BEAT_W = 24;
    localparam int LAG    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              play;
    logic              restart;
    logic [BEAT_W-1:0] tempo;
    logic [N-1:0]      voice_mute;
    logic [IDX_W-1:0]  loop_start;
    logic [IDX_W-1:0]  loop_end;
    logic [IDX_W-1:0]  rom_addr;
    logic [7:0]        rom_data;
    logic [5:0]        freq_note;
    logic [DIV_W-1:0]  freq_div;
    logic [SLOT_W-1:0] out_slot;
    logic [DIV_W-1:0]  divider_out;
    logic              out_valid;
    logic              beat;
    logic              loop_wrap;

    logic [7:0] rom [512];

    assign rom_data = rom[rom_addr];
    assign freq_div = 12'd408 + {5'd0, freq_note, 1'b0};

    canon_sequencer #(
        .NUM_VOICES(N), .SLOT_W(SLOT_W), .IDX_W(IDX_W),
        .DIV_W(DIV_W), .BEAT_W(BEAT_W), .VOICE_LAG(LAG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .restart(restart), .tempo(tempo),
        .voice_mute(voice_mute), .loop_start(loop_start), .loop_end(loop_end),
        .rom_addr(rom_addr), .rom_data(rom_data), .freq_note(freq_note),
        .freq_div(freq_div), .out_slot(out_slot), .divider_out(divider_out),
        .out_valid(out_valid), .beat(beat), .loop_wrap(loop_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: voice positions, beats heard while waiting to enter, and expected outputs.
    int m_slot, m_beatcnt;
    int m_idx [N];
    int m_el [N];
    int m_heard [N];
    bit m_pend [N];
    int e_slot, e_valid, e_div, e_beat, e_wrap;

    int cnt_beat, cnt_wrap, cnt_nz, cnt_s0_428, cnt_s1_nz, first_v1;

    task automatic checkVal(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input logic p, input logic rs, input int t,
                                 input logic [N-1:0] m, input int ls, input int le);
        play       = p;
        restart    = rs;
        tempo      = BEAT_W'(t);
        voice_mute = m;
        loop_start = IDX_W'(ls);
        loop_end   = IDX_W'(le);
    endtask

    task automatic modelStep();
        int s, a, note, code, period;
        bit entered, new_beat;
        if (!rst_n || restart) begin
            m_slot = 0; m_beatcnt = 0;
            for (int v = 0; v < N; v++) begin
                m_idx[v] = int'(loop_start); m_el[v] = 0; m_heard[v] = 0; m_pend[v] = 0;
            end
            e_slot = 0; e_valid = 0; e_div = 0; e_beat = 0; e_wrap = 0;
        end else begin
            s       = m_slot;
            a       = m_idx[s];
            note    = int'(rom[a][5:0]);
            code    = int'(rom[a][7:6]);
            entered = (m_heard[s] >= s * LAG);
            e_slot  = s;
            e_valid = 1;
            e_div   = (voice_mute[s] || !entered || !play || note == 0) ? 0 : 408 + 2 * note;
            e_wrap  = 0;
            period  = (int'(tempo) < N - 1) ? N : int'(tempo) + 1;
            new_beat = play && (m_beatcnt + 1 >= period);
            e_beat  = new_beat;
            if (play) m_beatcnt = new_beat ? 0 : m_beatcnt + 1;
            if (play && m_pend[s]) begin
                m_pend[s] = 0;
                if (!entered) m_heard[s]++;
                else if (m_el[s] + 1 >= 4 ** code) begin
                    m_el[s] = 0;
                    if (a >= int'(loop_end)) begin
                        m_idx[s] = int'(loop_start);
                        if (s == 0) e_wrap = 1;
                    end else m_idx[s] = a + 1;
                end else m_el[s]++;
            end
            if (new_beat) for (int v = 0; v < N; v++) m_pend[v] = 1;
            m_slot = (s + 1) % N;
        end
    endtask

    task automatic checkOutput();
        checkVal("out_valid", int'(out_valid), e_valid);
        checkVal("beat", int'(beat), e_beat);
        checkVal("loop_wrap", int'(loop_wrap), e_wrap);
        checkVal("out_slot", int'(out_slot), e_slot);
        checkVal("divider_out", int'(divider_out), e_div);
        checkVal("rom_addr", int'(rom_addr), m_idx[m_slot]);
    endtask

    task automatic clearCounts();
        cnt_beat = 0; cnt_wrap = 0; cnt_nz = 0; cnt_s0_428 = 0; cnt_s1_nz = 0; first_v1 = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
        if (beat) cnt_beat++;
        if (loop_wrap) cnt_wrap++;
        if (out_valid && divider_out != 0) cnt_nz++;
        if (out_valid && out_slot == 0 && divider_out == 428) cnt_s0_428++;
        if (out_valid && out_slot == 1 && divider_out != 0) begin
            cnt_s1_nz++;
            if (first_v1 < 0) first_v1 = cnt_beat;
        end
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        play    = 1'b1;
        tick();
        restart = 1'b0;
        clearCounts();
    endtask

    initial begin
        int guard;
        clearCounts();
        for (int i = 0; i < 512; i++) rom[i] = 8'h05;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 15, 4'b0000, 10, 12);
        tick();
        tick();
        checkVal("reset_valid", int'(out_valid), 0);
        checkVal("reset_div", int'(divider_out), 0);
        checkVal("reset_slot", int'(out_slot), 0);
        checkVal("reset_beat", int'(beat), 0);
        checkVal("reset_wrap", int'(loop_wrap), 0);
        rst_n = 1'b1;

        // Only voice 0 sounds right after reset.
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("t1_slot", int'(out_slot), i);
            checkVal("t1_div", int'(divider_out), (i == 0) ? 418 : 0);
        end

        // Looping 10..12 with staggered entry of voice 1.
        for (int i = 0; i < 512; i++) rom[i] = 8'(i & 63);
        pulseRestart();
        guard = 0;
        while (cnt_beat < 9 && guard < 2000) begin tick(); guard++; end
        for (int i = 0; i < 8; i++) tick();
        checkVal("t2_beats", cnt_beat, 9);
        checkVal("t2_wraps", cnt_wrap, 3);
        checkVal("t2_v1_entry_beat", first_v1, 8);

        // Four-beat note on idx 10.
        rom[10] = 8'h4A;
        pulseRestart();
        for (int i = 0; i < 100; i++) tick();
        checkVal("t3_beats", cnt_beat, 6);
        checkVal("t3_idx10_outputs", cnt_s0_428, 17);

        // Pause mid-note, then resume.
        clearCounts();
        play = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        checkVal("t4_pause_beats", cnt_beat, 0);
        checkVal("t4_pause_nonzero", cnt_nz, 0);
        play = 1'b1;
        for (int i = 0; i < 150; i++) tick();

        // Restart together with play once voice 0 reaches idx 12.
        guard = 0;
        while (m_idx[0] != 12 && guard < 1000) begin tick(); guard++; end
        checkVal("t5_reached_12", m_idx[0], 12);
        restart = 1'b1;
        play    = 1'b1;
        tick();
        restart = 1'b0;
        checkVal("t5_rom_addr", int'(rom_addr), 10);
        checkVal("t5_valid", int'(out_valid), 0);
        tick();
        checkVal("t5_valid_after", int'(out_valid), 1);

        // Voice 1 muted, then unmuted while in canon.
        rom[10] = 8'h0A;
        voice_mute = 4'b0010;
        pulseRestart();
        for (int i = 0; i < 400; i++) tick();
        checkVal("t6_muted_v1_nonzero", cnt_s1_nz, 0);
        voice_mute = 4'b0000;
        for (int i = 0; i < 40; i++) tick();
        checkVal("t6_unmuted_v1_sounds", int'(cnt_s1_nz > 0), 1);

        // Randomized play/tempo/mute/loop activity, including clamped tempos.
        for (int i = 0; i < 512; i++) begin
            rom[i] = 8'($urandom);
            if ($urandom_range(7) == 0) rom[i][5:0] = 6'd0;
            if ($urandom_range(1) == 0) rom[i][7] = 1'b0;
        end
        applyStimulus(1'b1, 1'b0, 1, 4'b0000, 3, 9);
        pulseRestart();
        for (int i = 0; i < 300; i++) tick();
        for (int i = 0; i < 3500; i++) begin
            tick();
            if ($urandom_range(49) == 0) play = ~play;
            if ($urandom_range(199) == 0) tempo = BEAT_W'($urandom_range(20));
            if ($urandom_range(99) == 0) voice_mute = N'($urandom);
            if ($urandom_range(299) == 0) begin
                loop_start = IDX_W'($urandom_range(20));
                loop_end   = IDX_W'($urandom_range(20));
            end
            restart = ($urandom_range(599) == 0);
        end
        restart = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
